// File: rtl/bias_weight_trainer_if.sv
// Predictor-side bus of the bias weight trainer: issue records in, resolutions
// in, table write port and status out. The master drives predictions and
// resolutions; the slave is the trainer itself.
interface bias_weight_trainer_if #(
  parameter int unsigned INDEX_W  = 10,
  parameter int unsigned WEIGHT_W = 2,
  parameter int unsigned DEPTH    = 4
) ();

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  // Prediction capture
  logic                pred_valid;
  logic [INDEX_W-1:0]  pred_index;
  logic [WEIGHT_W-1:0] pred_weight;
  logic                pred_dir;
  logic                pred_lowconf;
  logic                pred_ready;

  // Resolution and pipeline control
  logic                res_valid;
  logic                res_taken;
  logic                flush;

  // Table write port and status
  logic                wr_en;
  logic [INDEX_W-1:0]  wr_index;
  logic [WEIGHT_W-1:0] wr_weight;
  logic                mispredict;
  logic [OCC_W-1:0]    occupancy;
  logic                res_err;

  modport master (
    output pred_valid, pred_index, pred_weight, pred_dir, pred_lowconf,
    output res_valid, res_taken, flush,
    input  pred_ready, wr_en, wr_index, wr_weight, mispredict, occupancy, res_err
  );

  modport slave (
    input  pred_valid, pred_index, pred_weight, pred_dir, pred_lowconf,
    input  res_valid, res_taken, flush,
    output pred_ready, wr_en, wr_index, wr_weight, mispredict, occupancy, res_err
  );

endinterface

// File: rtl/bias_weight_trainer.sv
// Bias weight trainer: holds issued predictions in an in-order queue and, on
// each in-order resolution, computes the saturating weight update and drives
// the bias table write port one cycle later. Weights still queued for the
// same table entry are patched so consecutive aliasing branches train from
// the freshest value.
module bias_weight_trainer #(
  parameter int unsigned INDEX_W  = 10,
  parameter int unsigned WEIGHT_W = 2,
  parameter int unsigned DEPTH    = 4
) (
  input logic                  clk,
  input logic                  rst,
  bias_weight_trainer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  // Two's complement saturation limits, e.g. 2'b01 / 2'b10 for WEIGHT_W = 2
  localparam logic [WEIGHT_W-1:0] WMax = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] WMin = {1'b1, {(WEIGHT_W-1){1'b0}}};

  // Queue storage; contents need no reset, validity comes from occupancy
  logic [INDEX_W-1:0]  idx_q [DEPTH];
  logic [WEIGHT_W-1:0] w_q   [DEPTH];
  logic                dir_q [DEPTH];
  logic                lc_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;

  logic                wr_en_q;
  logic [INDEX_W-1:0]  wr_index_q;
  logic [WEIGHT_W-1:0] wr_weight_q;
  logic                mispredict_q;
  logic                res_err_q;

  logic                pred_ready;
  logic                push;
  logic                pop;
  logic [INDEX_W-1:0]  head_idx;
  logic [WEIGHT_W-1:0] head_w;
  logic                head_dir;
  logic                head_lc;
  logic                miss;
  logic                train;
  logic [WEIGHT_W-1:0] new_w;
  logic                patch;
  logic [WEIGHT_W-1:0] push_w;

  // Handshake decode, head lookup and the saturating update
  always_comb begin
    pred_ready = (occ_q < OCC_W'(DEPTH));
    // A flush drops any same-cycle push; a full queue refuses it
    push       = bus.pred_valid & pred_ready & ~bus.flush;
    pop        = bus.res_valid & (occ_q != '0);

    head_idx   = idx_q[rd_ptr_q];
    head_w     = w_q[rd_ptr_q];
    head_dir   = dir_q[rd_ptr_q];
    head_lc    = lc_q[rd_ptr_q];

    miss       = bus.res_taken ^ head_dir;
    train      = miss | head_lc;

    new_w = head_w;
    if (bus.res_taken) begin
      if (head_w != WMax) new_w = head_w + WEIGHT_W'(1);
    end else begin
      if (head_w != WMin) new_w = head_w - WEIGHT_W'(1);
    end

    patch  = pop & train;
    // An incoming record for the entry being written must see the new value
    push_w = (patch && (bus.pred_index == head_idx)) ? new_w : bus.pred_weight;
  end

  // Queue storage: coherence patch, then push (push slot is never a live entry)
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (patch && (idx_q[PTR_W'(i)] == head_idx)) begin
        w_q[PTR_W'(i)] <= new_w;
      end
    end
    if (push) begin
      idx_q[wr_ptr_q] <= bus.pred_index;
      w_q[wr_ptr_q]   <= push_w;
      dir_q[wr_ptr_q] <= bus.pred_dir;
      lc_q[wr_ptr_q]  <= bus.pred_lowconf;
    end
  end

  // Pointers and occupancy; flush wins over any push/pop bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop) begin
        occ_q <= occ_q + OCC_W'(1);
      end else if (pop && !push) begin
        occ_q <= occ_q - OCC_W'(1);
      end
    end
  end

  // Registered table write port and status; resolves still complete under flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q      <= 1'b0;
      wr_index_q   <= '0;
      wr_weight_q  <= '0;
      mispredict_q <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      wr_en_q      <= patch;
      mispredict_q <= pop & miss;
      if (patch) begin
        wr_index_q  <= head_idx;
        wr_weight_q <= new_w;
      end
      if (bus.res_valid && (occ_q == '0)) res_err_q <= 1'b1;
    end
  end

  assign bus.pred_ready = pred_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_index   = wr_index_q;
  assign bus.wr_weight  = wr_weight_q;
  assign bus.mispredict = mispredict_q;
  assign bus.occupancy  = occ_q;
  assign bus.res_err    = res_err_q;

endmodule
